// File: rtl/cpu_run_monitor_pkg.sv
// Shared constants, cause codes and FSM encoding for the CPU run monitor.
package cpu_run_monitor_pkg;

    localparam int unsigned ADDR_LEN  = 32;
    localparam int unsigned INSTR_LEN = 32;
    localparam int unsigned HOLD_W    = 8;
    localparam int unsigned STALL_W   = 8;
    localparam int unsigned CAUSE_W   = 2;

    localparam logic [31:0] HALT_INST_ENC = 32'hFFFF_FFFF;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE  = 2'b00;
    localparam logic [CAUSE_W-1:0] CAUSE_HALT  = 2'b01;
    localparam logic [CAUSE_W-1:0] CAUSE_STALL = 2'b10;
    localparam logic [CAUSE_W-1:0] CAUSE_BP    = 2'b11;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cpu_run_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller: stretches CPU reset, counts run cycles and detects termination
// by halt instruction, pc breakpoint, pc livelock or cycle timeout.
module cpu_run_monitor
    import cpu_run_monitor_pkg::*;
#(
    parameter int unsigned      ADDR_W      = ADDR_LEN,
    parameter int unsigned      INST_W      = INSTR_LEN,
    parameter int unsigned      RST_CYCLES  = 1,
    parameter int unsigned      MAX_CYCLES  = 50,
    parameter int unsigned      STALL_LIMIT = 8,
    parameter logic [INST_W-1:0] HALT_INST  = INST_W'(HALT_INST_ENC),
    parameter int unsigned      CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pc,
    input  logic [INST_W-1:0]   inst,
    input  logic                bp_en,
    input  logic [ADDR_W-1:0]   bp_addr,
    output logic                cpu_rst,
    output logic                running,
    output logic                done,
    output logic                timeout,
    output logic [CAUSE_W-1:0]  halt_cause,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    pc_change_cnt,
    output logic [ADDR_W-1:0]   final_pc
);

    state_t              state, state_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [STALL_W-1:0]  stall_cnt;
    logic [ADDR_W-1:0]   prev_pc, prev_pc_nxt;
    logic                prev_valid, prev_valid_nxt;
    logic                cpu_rst_nxt, running_nxt, done_nxt, timeout_nxt;
    logic [CAUSE_W-1:0]  cause_nxt;
    logic [ADDR_W-1:0]   final_pc_nxt;
    logic                cyc_inc, chg_inc, stall_inc, stall_clr, pc_chg;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk), .clr (rst), .inc (cyc_inc), .cnt (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_pc_change_cnt (
        .clk (clk), .clr (rst), .inc (chg_inc), .cnt (pc_change_cnt)
    );

    sat_counter #(.W(STALL_W)) u_stall_cnt (
        .clk (clk), .clr (rst | stall_clr), .inc (stall_inc), .cnt (stall_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_HOLD;
            hold_cnt   <= '0;
            prev_pc    <= '0;
            prev_valid <= 1'b0;
            cpu_rst    <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            halt_cause <= CAUSE_NONE;
            final_pc   <= '0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_nxt;
            prev_pc    <= prev_pc_nxt;
            prev_valid <= prev_valid_nxt;
            cpu_rst    <= cpu_rst_nxt;
            running    <= running_nxt;
            done       <= done_nxt;
            timeout    <= timeout_nxt;
            halt_cause <= cause_nxt;
            final_pc   <= final_pc_nxt;
        end
    end

    // The first RUN cycle has no valid previous pc and always counts as a change.
    assign pc_chg = !prev_valid || (pc != prev_pc);

    always_comb begin
        state_nxt      = state;
        hold_nxt       = hold_cnt;
        prev_pc_nxt    = prev_pc;
        prev_valid_nxt = prev_valid;
        done_nxt       = done;
        timeout_nxt    = timeout;
        cause_nxt      = halt_cause;
        final_pc_nxt   = final_pc;
        cyc_inc        = 1'b0;
        chg_inc        = 1'b0;
        stall_inc      = 1'b0;
        stall_clr      = 1'b0;

        case (state)
            ST_HOLD: begin
                hold_nxt = hold_cnt + HOLD_W'(1);
                if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                cyc_inc        = 1'b1;
                chg_inc        = pc_chg;
                stall_clr      = pc_chg;
                stall_inc      = !pc_chg;
                prev_pc_nxt    = pc;
                prev_valid_nxt = 1'b1;

                // Termination sources in priority order.
                if (inst == HALT_INST) begin
                    state_nxt = ST_DONE;
                    cause_nxt = CAUSE_HALT;
                end else if (bp_en && (pc == bp_addr)) begin
                    state_nxt = ST_DONE;
                    cause_nxt = CAUSE_BP;
                end else if (!pc_chg && (stall_cnt == STALL_W'(STALL_LIMIT - 1))) begin
                    state_nxt = ST_DONE;
                    cause_nxt = CAUSE_STALL;
                end else if (cycle_cnt == CNT_W'(MAX_CYCLES - 1)) begin
                    state_nxt   = ST_DONE;
                    cause_nxt   = CAUSE_BP;
                    timeout_nxt = 1'b1;
                end

                if (state_nxt == ST_DONE) begin
                    done_nxt     = 1'b1;
                    final_pc_nxt = pc;
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_HOLD;
            end
        endcase

        cpu_rst_nxt = (state_nxt != ST_RUN);
        running_nxt = (state_nxt == ST_RUN);
    end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomized self-checking bench for cpu_run_monitor against a sequence-level model.
module tb_cpu_run_monitor;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned INST_W      = 32;
    localparam int unsigned RST_CYCLES  = 3;
    localparam int unsigned MAX_CYCLES  = 50;
    localparam int unsigned STALL_LIMIT = 8;
    localparam int unsigned CNT_W       = 32;
    localparam logic [31:0] HALT        = 32'hFFFF_FFFF;
    localparam int          SEQ_LEN     = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              bp_en;
    logic [ADDR_W-1:0] bp_addr;
    logic              cpu_rst, running, done, timeout;
    logic [1:0]        halt_cause;
    logic [CNT_W-1:0]  cycle_cnt, pc_change_cnt;
    logic [ADDR_W-1:0] final_pc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0] pc_seq    [SEQ_LEN];
    logic [INST_W-1:0] inst_seq  [SEQ_LEN];
    logic              bp_en_seq [SEQ_LEN];

    int                exp_n;
    logic [1:0]        exp_cause;
    logic              exp_tmo;
    int                exp_chg;
    logic [ADDR_W-1:0] exp_final;

    cpu_run_monitor #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .RST_CYCLES(RST_CYCLES),
        .MAX_CYCLES(MAX_CYCLES), .STALL_LIMIT(STALL_LIMIT),
        .HALT_INST(HALT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .pc(pc), .inst(inst), .bp_en(bp_en), .bp_addr(bp_addr),
        .cpu_rst(cpu_rst), .running(running), .done(done), .timeout(timeout),
        .halt_cause(halt_cause), .cycle_cnt(cycle_cnt), .pc_change_cnt(pc_change_cnt),
        .final_pc(final_pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [99:0] observed();
        return {done, halt_cause, timeout, cycle_cnt, pc_change_cnt, final_pc};
    endfunction

    function automatic logic [99:0] expected();
        return {1'b1, exp_cause, exp_tmo, CNT_W'(exp_n), CNT_W'(exp_chg), exp_final};
    endfunction

    // Walks the program as a list of pcs: the run ends at the first cycle that
    // hits a halt, a breakpoint, the STALL_LIMIT-th repeat of a pc, or MAX_CYCLES.
    task automatic model_run();
        int repeats = 0;
        exp_n = -1; exp_chg = 0; exp_cause = 2'b00; exp_tmo = 1'b0; exp_final = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            bit same = 1'b0;
            if (i > 0) same = (pc_seq[i] == pc_seq[i-1]);
            if (same) repeats++;
            else begin repeats = 0; exp_chg++; end
            if (inst_seq[i] == HALT)                          exp_cause = 2'b01;
            else if (bp_en_seq[i] && pc_seq[i] == bp_addr)    exp_cause = 2'b11;
            else if (repeats == int'(STALL_LIMIT))            exp_cause = 2'b10;
            else if (i + 1 == int'(MAX_CYCLES)) begin exp_cause = 2'b11; exp_tmo = 1'b1; end
            if (exp_cause != 2'b00) begin
                exp_n = i + 1;
                exp_final = pc_seq[i];
                break;
            end
        end
    endtask

    task automatic fill_linear(input logic [ADDR_W-1:0] base);
        for (int i = 0; i < SEQ_LEN; i++) begin
            pc_seq[i]    = base + ADDR_W'(4 * i);
            inst_seq[i]  = $urandom() & 32'h7FFF_FFFF;
            bp_en_seq[i] = 1'b0;
        end
    endtask

    // Releases rst and waits out the reset stretch; leaves the bench at RUN cycle 1.
    task automatic release_and_wait();
        rst = 1'b0;
        repeat (RST_CYCLES) step();
        n_checks++;
        if (running !== 1'b1 || cpu_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL enter_run: running=%b cpu_rst=%b, wanted running=1 cpu_rst=0", running, cpu_rst);
        end
    endtask

    task automatic go_to_run();
        rst = 1'b1; pc = '0; inst = '0; bp_en = 1'b0;
        repeat (2) step();
        release_and_wait();
    endtask

    task automatic drive_run(output int seen);
        seen = -1;
        for (int i = 0; i < SEQ_LEN; i++) begin
            pc = pc_seq[i]; inst = inst_seq[i]; bp_en = bp_en_seq[i];
            step();
            if (done === 1'b1) begin
                seen = i + 1;
                break;
            end
        end
        pc = '0; inst = '0; bp_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc = '0; inst = '0; bp_en = 1'b0; bp_addr = '0;
        repeat (2) step();
        n_checks++;
        if ({cpu_rst, running, done, timeout, halt_cause} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: cpu_rst,running,done,timeout,cause=%b wanted 100000",
                     {cpu_rst, running, done, timeout, halt_cause});
        end
        n_checks++;
        if ({cycle_cnt, pc_change_cnt, final_pc} !== '0) begin
            n_fail++;
            $display("FAIL reset_counts: cycle=%0d chg=%0d final_pc=%h wanted 0 0 0",
                     cycle_cnt, pc_change_cnt, final_pc);
        end
        rst = 1'b0;
        for (int k = 0; k < int'(RST_CYCLES); k++) begin
            n_checks++;
            if (cpu_rst !== 1'b1 || running !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_stretch[%0d]: cpu_rst=%b running=%b wanted 1 0", k, cpu_rst, running);
            end
            step();
        end
        n_checks++;
        if (cpu_rst !== 1'b0 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: cpu_rst=%b running=%b wanted 0 1", cpu_rst, running);
        end
    endtask

    task automatic test_halt();
        int seen;
        fill_linear('0);
        inst_seq[9] = HALT;
        model_run();
        go_to_run();
        drive_run(seen);
        n_checks++;
        if (seen !== exp_n) begin
            n_fail++;
            $display("FAIL halt_latency: done after %0d cycles, wanted %0d", seen, exp_n);
        end
        n_checks++;
        if (observed() !== expected()) begin
            n_fail++;
            $display("FAIL halt_result: got %h wanted %h", observed(), expected());
        end
        // Frozen in DONE regardless of inputs.
        for (int k = 0; k < 3; k++) begin
            pc = $urandom(); inst = HALT; bp_en = 1'b1;
            step();
        end
        n_checks++;
        if (observed() !== expected() || cpu_rst !== 1'b1 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL done_frozen: got %h cpu_rst=%b running=%b wanted %h 1 0",
                     observed(), cpu_rst, running, expected());
        end
    endtask

    task automatic test_livelock();
        int seen;
        fill_linear('0);
        for (int i = 4; i < SEQ_LEN; i++) pc_seq[i] = 32'h0000_0040;
        model_run();
        go_to_run();
        drive_run(seen);
        n_checks++;
        if (seen !== exp_n || exp_cause !== 2'b10) begin
            n_fail++;
            $display("FAIL livelock_latency: done after %0d cycles, wanted %0d (model cause %b)",
                     seen, exp_n, exp_cause);
        end
        n_checks++;
        if (observed() !== expected()) begin
            n_fail++;
            $display("FAIL livelock_result: got %h wanted %h", observed(), expected());
        end
    endtask

    task automatic test_breakpoint();
        int seen;
        fill_linear('0);
        for (int i = 0; i < SEQ_LEN; i++) bp_en_seq[i] = 1'b1;
        bp_addr = 32'h0000_0020;
        model_run();
        go_to_run();
        drive_run(seen);
        n_checks++;
        if (seen !== exp_n) begin
            n_fail++;
            $display("FAIL bp_latency: done after %0d cycles, wanted %0d", seen, exp_n);
        end
        n_checks++;
        if (observed() !== expected() || final_pc !== 32'h0000_0020) begin
            n_fail++;
            $display("FAIL bp_result: got %h wanted %h", observed(), expected());
        end
    endtask

    task automatic test_timeout();
        int seen;
        for (int pass = 0; pass < 2; pass++) begin
            fill_linear(32'h0000_1000);
            if (pass == 1) inst_seq[MAX_CYCLES-1] = HALT;
            model_run();
            go_to_run();
            drive_run(seen);
            n_checks++;
            if (seen !== exp_n) begin
                n_fail++;
                $display("FAIL timeout_latency[%0d]: done after %0d cycles, wanted %0d", pass, seen, exp_n);
            end
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL timeout_result[%0d]: got %h wanted %h", pass, observed(), expected());
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        fill_linear(32'h0000_0100);
        go_to_run();
        for (int i = 0; i < 19; i++) begin
            pc = pc_seq[i]; inst = inst_seq[i];
            step();
        end
        rst = 1'b1;
        step();
        n_checks++;
        if ({cycle_cnt, pc_change_cnt} !== '0 || done !== 1'b0 || cpu_rst !== 1'b1 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: cycle=%0d chg=%0d done=%b cpu_rst=%b running=%b wanted 0 0 0 1 0",
                     cycle_cnt, pc_change_cnt, done, cpu_rst, running);
        end
        release_and_wait();
        fill_linear(32'h0000_0200);
        inst_seq[6] = HALT;
        model_run();
        drive_run(seen);
        n_checks++;
        if (seen !== exp_n || observed() !== expected()) begin
            n_fail++;
            $display("FAIL midrun_restart: after %0d cycles got %h, wanted %0d cycles %h",
                     seen, observed(), exp_n, expected());
        end
    endtask

    task automatic test_random();
        int seen;
        for (int it = 0; it < 24; it++) begin
            int stick = $urandom_range(1, 15);
            logic bp_on = ($urandom_range(0, 1) == 1);
            bp_addr = ADDR_W'(4 * $urandom_range(0, 15));
            pc_seq[0] = ADDR_W'(4 * $urandom_range(0, 15));
            for (int i = 0; i < SEQ_LEN; i++) begin
                if (i > 0) begin
                    if ($urandom_range(0, 15) < stick) pc_seq[i] = pc_seq[i-1];
                    else pc_seq[i] = ADDR_W'(4 * $urandom_range(0, 15));
                end
                inst_seq[i]  = ($urandom_range(0, 63) == 0) ? HALT : ($urandom() & 32'h7FFF_FFFF);
                bp_en_seq[i] = bp_on && ($urandom_range(0, 3) != 0);
            end
            model_run();
            go_to_run();
            drive_run(seen);
            n_checks++;
            if (seen !== exp_n || observed() !== expected()) begin
                n_fail++;
                $display("FAIL random[%0d]: after %0d cycles got %h, wanted %0d cycles %h",
                         it, seen, observed(), exp_n, expected());
            end
        end
    endtask

    initial begin
        test_reset();
        test_halt();
        test_livelock();
        test_breakpoint();
        test_timeout();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
